// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS core; drives all datapath and memory strobes.
// Optional bne support is enabled by defining MULTICYCLE_CTRL_BNE_EN.
module multicycle_controller #(
    parameter logic PC_EN_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       memtoreg,
    output logic       regdst,
    output logic [2:0] alucont,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MULTICYCLE_CTRL_BNE_EN
        ,BNEEX  = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_r, state_nx;

    // Returns {valid, alucont} for an R-type funct field.
    function automatic logic [3:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: rtype_alu = 4'b1_010;
            6'b100010: rtype_alu = 4'b1_110;
            6'b100100: rtype_alu = 4'b1_000;
            6'b100101: rtype_alu = 4'b1_001;
            6'b101010: rtype_alu = 4'b1_111;
            default:   rtype_alu = 4'b0_010;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= FETCH;
        else        state_r <= state_nx;
    end

    always_comb begin
        logic [3:0] rdec;
        rdec     = rtype_alu(funct);
        state_nx = FETCH;
        pcen     = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alucont  = 3'b010;
        illegal  = 1'b0;
        case (state_r)
            FETCH: begin
                irwrite  = 1'b1;
                alusrcb  = 2'b01;
                pcsrc    = 2'b01;
                // reset holds state in FETCH, so this is where the reset-time pcen lives
                pcen     = reset ? 1'b1 : PC_EN_ON_RESET;
                state_nx = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_RTYPE:     state_nx = RTYPEEX;
                    OP_BEQ:       state_nx = BEQEX;
                    OP_ADDI:      state_nx = ADDIEX;
                    OP_J:         state_nx = JEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:       state_nx = BNEEX;
`endif
                    default:      illegal  = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW)      state_nx = MEMRD;
                else if (op == OP_SW) state_nx = MEMWR;
            end
            MEMRD: begin
                iord     = 1'b1;
                state_nx = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                alucont = rdec[2:0];
                if (rdec[3]) state_nx = RTYPEWB;
                else         illegal  = 1'b1;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                alucont = 3'b110;
                pcen    = zero;
            end
`ifdef MULTICYCLE_CTRL_BNE_EN
            BNEEX: begin
                alusrca = 1'b1;
                alucont = 3'b110;
                pcen    = ~zero;
            end
`endif
            ADDIEX: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                state_nx = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: state_nx = FETCH;
        endcase
    end

    // OP_BNE is only decoded when the bne feature is built in.
    logic unused_bne;
    assign unused_bne = (op == OP_BNE);

    assign state = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table, reset corner cases and
// randomized instructions checked against an instruction-level expected-trace model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'b100011;
    logic [5:0] funct = 6'b000000;
    logic       zero = 1'b0;
    logic       pcen, irwrite, iord, memwrite, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       memtoreg, regdst;
    logic [2:0] alucont;
    logic       illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .memtoreg(memtoreg), .regdst(regdst), .alucont(alucont),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam bit BNE_ON = 1'b1;
`else
    localparam bit BNE_ON = 1'b0;
`endif

    // Packed observation: {state, pcen, irwrite, iord, memwrite, regwrite, alusrca,
    // alusrcb, pcsrc, memtoreg, regdst, alucont, illegal}
    logic [19:0] exp_q[$];

    function automatic logic [19:0] pk(input int s, input logic pe, input logic irw,
        input logic io, input logic mw, input logic rw, input logic asa,
        input logic [1:0] asb, input logic [1:0] ps, input logic m2r,
        input logic rd, input logic [2:0] ac, input logic ill);
        logic [3:0] s4;
        s4 = s[3:0];
        return {s4, pe, irw, io, mw, rw, asa, asb, ps, m2r, rd, ac, ill};
    endfunction

    function automatic logic [19:0] observe();
        return {state, pcen, irwrite, iord, memwrite, regwrite, alusrca,
                alusrcb, pcsrc, memtoreg, regdst, alucont, illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected per-cycle trace of one instruction, listed phase by phase.
    task automatic build_trace(input logic [5:0] o, input logic [5:0] f, input logic z);
        bit known;
        bit fvalid;
        logic [2:0] ac;
        exp_q.delete();
        known = (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
                (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010) ||
                (BNE_ON && o == 6'b000101);
        fvalid = 1'b1;
        case (f)
            6'b100000: ac = 3'b010;
            6'b100010: ac = 3'b110;
            6'b100100: ac = 3'b000;
            6'b100101: ac = 3'b001;
            6'b101010: ac = 3'b111;
            default: begin ac = 3'b010; fvalid = 1'b0; end
        endcase
        exp_q.push_back(pk(0, 1, 1, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 3'b010, 0));
        exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 3'b010, !known));
        if (o == 6'b100011) begin
            exp_q.push_back(pk(2, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b010, 0));
            exp_q.push_back(pk(3, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b010, 0));
            exp_q.push_back(pk(4, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 3'b010, 0));
        end else if (o == 6'b101011) begin
            exp_q.push_back(pk(2, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b010, 0));
            exp_q.push_back(pk(5, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b010, 0));
        end else if (o == 6'b000000) begin
            exp_q.push_back(pk(6, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, ac, !fvalid));
            if (fvalid)
                exp_q.push_back(pk(7, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 3'b010, 0));
        end else if (o == 6'b000100) begin
            exp_q.push_back(pk(8, z, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 3'b110, 0));
        end else if (BNE_ON && o == 6'b000101) begin
            exp_q.push_back(pk(12, !z, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 3'b110, 0));
        end else if (o == 6'b001000) begin
            exp_q.push_back(pk(9, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b010, 0));
            exp_q.push_back(pk(10, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3'b010, 0));
        end else if (o == 6'b000010) begin
            exp_q.push_back(pk(11, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 3'b010, 0));
        end
    endtask

    // Runs one instruction from FETCH until the FSM is back in FETCH; called at posedge+1.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, output int cyc, output int last,
                             output logic pl, output int ill, output int rw, output int mw);
        logic [19:0] obs;
        build_trace(o, f, z);
        op = o; funct = f; zero = z;
        cyc = 0; last = 0; pl = 1'b0; ill = 0; rw = 0; mw = 0;
        do begin
            @(negedge clk);
            obs = observe();
            if (cyc < exp_q.size()) begin
                chk($sformatf("%s_c%0d", name, cyc), {12'd0, obs}, {12'd0, exp_q[cyc]});
            end else begin
                checks++; errors++;
                $display("FAIL %s_extra_cycle: got state %0d expected return to 0", name, state);
            end
            last = int'(state); pl = pcen;
            ill += int'(illegal); rw += int'(regwrite); mw += int'(memwrite);
            cyc++;
            @(posedge clk); #1;
        end while (state != 4'd0 && cyc < 10);
        if (state != 4'd0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got state %0d expected 0 within 10 cycles", name, state);
        end
        chk({name, "_len"}, cyc, exp_q.size());
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cyc;
        int         last;
        logic       pcen_last;
        int         ill;
        int         rw;
        int         mw;
    } vec_t;

    initial begin
        vec_t tbl[11];
        int cyc, last, ill, rw, mw;
        logic pl;

        tbl[0]  = '{"lw",     6'b100011, 6'b000000, 1'b0, 5, 4,  1'b0, 0, 1, 0};
        tbl[1]  = '{"sw",     6'b101011, 6'b000000, 1'b0, 4, 5,  1'b0, 0, 0, 1};
        tbl[2]  = '{"add",    6'b000000, 6'b100000, 1'b0, 4, 7,  1'b0, 0, 1, 0};
        tbl[3]  = '{"slt",    6'b000000, 6'b101010, 1'b1, 4, 7,  1'b0, 0, 1, 0};
        tbl[4]  = '{"beq_z1", 6'b000100, 6'b000000, 1'b1, 3, 8,  1'b1, 0, 0, 0};
        tbl[5]  = '{"beq_z0", 6'b000100, 6'b000000, 1'b0, 3, 8,  1'b0, 0, 0, 0};
        tbl[6]  = '{"addi",   6'b001000, 6'b000000, 1'b0, 4, 10, 1'b0, 0, 1, 0};
        tbl[7]  = '{"j",      6'b000010, 6'b000000, 1'b0, 3, 11, 1'b1, 0, 0, 0};
        tbl[8]  = '{"badop",  6'b111111, 6'b000000, 1'b0, 2, 1,  1'b0, 1, 0, 0};
        tbl[9]  = '{"badfn",  6'b000000, 6'b000111, 1'b0, 3, 6,  1'b0, 1, 0, 0};
`ifdef MULTICYCLE_CTRL_BNE_EN
        tbl[10] = '{"bne_z0", 6'b000101, 6'b000000, 1'b0, 3, 12, 1'b1, 0, 0, 0};
`else
        tbl[10] = '{"bne_z0", 6'b000101, 6'b000000, 1'b0, 2, 1,  1'b0, 1, 0, 0};
`endif

        // Reset held for three cycles with lw on the bus.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_state", state, 0);
            chk("reset_irwrite", irwrite, 1);
            chk("reset_pcen", pcen, 1);
            chk("reset_quiet", {illegal, regwrite, memwrite}, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].name, tbl[i].op, tbl[i].funct, tbl[i].zero,
                      cyc, last, pl, ill, rw, mw);
            chk({tbl[i].name, "_cycles"}, cyc, tbl[i].cyc);
            chk({tbl[i].name, "_laststate"}, last, tbl[i].last);
            chk({tbl[i].name, "_pcenlast"}, pl, tbl[i].pcen_last);
            chk({tbl[i].name, "_illegal"}, ill, tbl[i].ill);
            chk({tbl[i].name, "_regwrite"}, rw, tbl[i].rw);
            chk({tbl[i].name, "_memwrite"}, mw, tbl[i].mw);
        end

        // sw interrupted by reset while in MEMADR.
        op = 6'b101011; funct = 6'b000000; zero = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (state != 4'd2 && n < 10);
            chk("sw_reach_memadr", state, 2);
            reset = 1'b0;
            #1;
            chk("async_reset_state", state, 0);
            chk("async_reset_memwrite", memwrite, 0);
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("midreset_memwrite", memwrite, 0);
                chk("midreset_regwrite", regwrite, 0);
                chk("midreset_state", state, 0);
            end
            @(posedge clk); #1;
            reset = 1'b1;
            chk("release_state", state, 0);
        end

        // Randomized instruction stream against the trace model.
        for (int k = 0; k < 80; k++) begin
            logic [5:0] o, f;
            logic z;
            case ($urandom_range(0, 7))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                6: o = 6'b000101;
                default: o = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: f = 6'b100000;
                1: f = 6'b100010;
                2: f = 6'b100100;
                3: f = 6'b100101;
                4: f = 6'b101010;
                default: f = 6'($urandom);
            endcase
            z = 1'($urandom);
            run_instr($sformatf("rnd%0d", k), o, f, z, cyc, last, pl, ill, rw, mw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
